// File: rtl/bar_peak_decay_if.sv
// Update/readback bus between the bar normaliser, bar_peak_decay and the display renderer.
// master = producer/renderer side, slave = bar_peak_decay.
interface bar_peak_decay_if #(
  parameter int unsigned BwBar  = 7,
  parameter int unsigned BwAddr = 5
);
  logic              Start;
  logic [BwAddr-1:0] Addr;
  logic [BwBar-1:0]  In;
  logic              Clear;
  logic              Busy;
  logic              End;
  logic [BwBar-1:0]  Level;
  logic [BwBar-1:0]  Peak;
  logic [BwAddr-1:0] Rd_Addr;
  logic [BwBar-1:0]  Rd_Level;
  logic [BwBar-1:0]  Rd_Peak;

  modport master (
    output Start, Addr, In, Clear, Rd_Addr,
    input  Busy, End, Level, Peak, Rd_Level, Rd_Peak
  );

  modport slave (
    input  Start, Addr, In, Clear, Rd_Addr,
    output Busy, End, Level, Peak, Rd_Level, Rd_Peak
  );
endinterface

// File: rtl/bar_peak_decay.sv
// Per-bin bar level decay and peak-hold with a registered display read port.
// Optional feature macro: PEAK_HOLD_EN (peak[]/hold[] storage; otherwise Peak mirrors Level).
module bar_peak_decay #(
  parameter int unsigned BwBar      = 7,
  parameter int unsigned BwAddr     = 5,
  parameter int unsigned NBins      = 32,
  parameter int unsigned BarMax     = 96,
  parameter int unsigned DecayStep  = 2,
  parameter int unsigned HoldFrames = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  bar_peak_decay_if.slave bus
);

  localparam int unsigned Aw = BwBar + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE, CLR} state_t;

  state_t            state;
  logic [BwBar-1:0]  xQ;
  logic [BwAddr-1:0] addrQ;
  logic [BwAddr-1:0] clrCnt;
  logic [BwBar-1:0]  levelMem [NBins];

  logic             addrOk_c;
  logic             rdOk_c;
  logic [BwBar-1:0] xClamp_c;
  logic [Aw-1:0]    xExt_c;
  logic [Aw-1:0]    oldLevel_c;
  logic [Aw-1:0]    decayed_c;
  logic [Aw-1:0]    levelNew_c;
  logic [Aw-1:0]    peakNew_c;

  assign addrOk_c = 32'(addrQ) < NBins;
  assign rdOk_c   = 32'(bus.Rd_Addr) < NBins;
  assign xClamp_c = (32'(bus.In) > BarMax) ? BwBar'(BarMax) : bus.In;
  assign xExt_c   = Aw'(xQ);

  // Level decays by DecayStep but never drops below the fresh input.
  always_comb begin
    oldLevel_c = '0;
    if (addrOk_c) oldLevel_c = Aw'(levelMem[addrQ]);
    decayed_c  = (oldLevel_c >= Aw'(DecayStep)) ? oldLevel_c - Aw'(DecayStep) : '0;
    levelNew_c = (xExt_c >= decayed_c) ? xExt_c : decayed_c;
  end

`ifdef PEAK_HOLD_EN
  localparam int unsigned Hw = $clog2(HoldFrames + 1);

  logic [BwBar-1:0] peakMem [NBins];
  logic [Hw-1:0]    holdMem [NBins];
  logic [Aw-1:0]    oldPeak_c;
  logic [Aw-1:0]    peakDec_c;
  logic [Hw-1:0]    oldHold_c;
  logic [Hw-1:0]    holdNew_c;

  // New peak re-arms the hold timer; once expired the peak falls by one, never below level.
  always_comb begin
    oldPeak_c = '0;
    oldHold_c = '0;
    if (addrOk_c) begin
      oldPeak_c = Aw'(peakMem[addrQ]);
      oldHold_c = holdMem[addrQ];
    end
    peakDec_c = (oldPeak_c != '0) ? oldPeak_c - Aw'(1) : '0;
    if (xExt_c >= oldPeak_c) begin
      peakNew_c = xExt_c;
      holdNew_c = Hw'(HoldFrames);
    end else if (oldHold_c != '0) begin
      peakNew_c = oldPeak_c;
      holdNew_c = oldHold_c - Hw'(1);
    end else begin
      peakNew_c = (levelNew_c >= peakDec_c) ? levelNew_c : peakDec_c;
      holdNew_c = '0;
    end
  end
`else
  localparam int unsigned unusedHoldFrames = HoldFrames;

  assign peakNew_c = levelNew_c;
`endif

  // Control FSM, bin storage, result registers and the display read port.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      xQ           <= '0;
      addrQ        <= '0;
      clrCnt       <= '0;
      bus.Busy     <= 1'b0;
      bus.End      <= 1'b0;
      bus.Level    <= '0;
      bus.Peak     <= '0;
      bus.Rd_Level <= '0;
      bus.Rd_Peak  <= '0;
      for (int i = 0; i < NBins; i++) begin
        levelMem[i] <= '0;
`ifdef PEAK_HOLD_EN
        peakMem[i]  <= '0;
        holdMem[i]  <= '0;
`endif
      end
    end else begin
      bus.End      <= 1'b0;
      bus.Rd_Level <= rdOk_c ? levelMem[bus.Rd_Addr] : '0;
`ifdef PEAK_HOLD_EN
      bus.Rd_Peak  <= rdOk_c ? peakMem[bus.Rd_Addr] : '0;
`else
      bus.Rd_Peak  <= rdOk_c ? levelMem[bus.Rd_Addr] : '0;
`endif

      case (state)
        IDLE: begin
          if (bus.Clear) begin
            clrCnt   <= '0;
            bus.Busy <= 1'b1;
            state    <= CLR;
          end else if (bus.Start) begin
            xQ       <= xClamp_c;
            addrQ    <= bus.Addr;
            bus.Busy <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (addrOk_c) begin
            levelMem[addrQ] <= BwBar'(levelNew_c);
`ifdef PEAK_HOLD_EN
            peakMem[addrQ]  <= BwBar'(peakNew_c);
            holdMem[addrQ]  <= holdNew_c;
`endif
            bus.Level <= BwBar'(levelNew_c);
            bus.Peak  <= BwBar'(peakNew_c);
          end else begin
            bus.Level <= '0;
            bus.Peak  <= '0;
          end
          bus.End <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          bus.Busy <= 1'b0;
          state    <= IDLE;
        end
        CLR: begin
          levelMem[clrCnt] <= '0;
`ifdef PEAK_HOLD_EN
          peakMem[clrCnt]  <= '0;
          holdMem[clrCnt]  <= '0;
`endif
          if (clrCnt == BwAddr'(NBins - 1)) begin
            bus.Busy <= 1'b0;
            state    <= IDLE;
          end else begin
            clrCnt <= clrCnt + BwAddr'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
